regfile_wb_arbiter: RTL

//   Sole owner of the register-file write port (write enable, write address, write data).

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter_arb.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file writeback arbiter.
// Optional feature macro: RR_ARB_EN (round-robin arbitration; fixed priority otherwise).
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: requester handshake plus the register-file write port.
// The arbiter side uses the master modport, requesters/environment use slave.
interface regfile_wb_if
    import regfile_pkg::*;
#(
    parameter int N_REQ = 3
);
    logic                    soft_init;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*REG_AW-1:0] req_addr;
    logic [N_REQ*XLEN-1:0]   req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rf_wr;
    logic [REG_AW-1:0]       rf_addr;
    logic [XLEN-1:0]         rf_data;
    logic                    init_done;

    modport master (
        input  soft_init, req_valid, req_addr, req_data,
        output req_ready, rf_wr, rf_addr, rf_data, init_done
    );

    modport slave (
        output soft_init, req_valid, req_addr, req_data,
        input  req_ready, rf_wr, rf_addr, rf_data, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter_arb.sv
// Writeback request arbiter: valid vector in, one-hot grant and index out.
// With RR_ARB_EN defined the search starts at i_rr_ptr and wraps; otherwise
// it is a plain priority encoder where the lowest valid index wins.
module wb_rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_valid,
`ifdef RR_ARB_EN
    input  logic [PTR_W-1:0] i_rr_ptr,
`endif
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

`ifdef RR_ARB_EN
    // Rotating search: first valid index at or after the pointer, wrapping around.
    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(i_rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PTR_W'(j);
            end
        end
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && i_valid[k]) begin
                o_any      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = PTR_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero-sweeps all registers after reset or
// soft_init, then arbitrates writeback requesters onto the single write port.
// Writes to x0 complete their handshake but never assert rf_wr.
// Optional feature macro: RR_ARB_EN selects round-robin instead of fixed priority.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_if.master      bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [REG_AW-1:0]   r_sweep_cnt;
    logic                w_sweep_last;
    logic [N_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]    w_idx;
    logic                w_any;
    logic                w_xfer;
    logic [REG_AW-1:0]   w_sel_addr;
    logic [XLEN-1:0]     w_sel_data;

`ifdef RR_ARB_EN
    logic [PTR_W-1:0]    r_rr_ptr;
`endif

    wb_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_valid  (bus.req_valid),
`ifdef RR_ARB_EN
        .i_rr_ptr (r_rr_ptr),
`endif
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_sweep_last = (r_sweep_cnt == REG_AW'(NUM_REGS - 1));
    assign w_sel_addr   = bus.req_addr[w_idx*REG_AW +: REG_AW];
    assign w_sel_data   = bus.req_data[w_idx*XLEN +: XLEN];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_next_state;
    end

    // Next state and combinational grant; soft_init in RUN suppresses the grant.
    always_comb begin
        w_next_state  = r_state;
        bus.req_ready = '0;
        w_xfer        = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_sweep_last) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (bus.soft_init) begin
                    w_next_state = ST_INIT;
                end else begin
                    bus.req_ready = w_grant;
                    w_xfer        = w_any;
                end
            end
            default: w_next_state = ST_INIT;
        endcase
    end

    // Sweep counter, done flag and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep_cnt   <= '0;
            bus.rf_wr     <= 1'b0;
            bus.rf_addr   <= '0;
            bus.rf_data   <= '0;
            bus.init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            bus.rf_wr     <= 1'b1;
            bus.rf_addr   <= r_sweep_cnt;
            bus.rf_data   <= '0;
            r_sweep_cnt   <= w_sweep_last ? '0 : r_sweep_cnt + 1'b1;
            bus.init_done <= w_sweep_last;
        end else if (bus.soft_init) begin
            bus.rf_wr     <= 1'b0;
            r_sweep_cnt   <= '0;
            bus.init_done <= 1'b0;
        end else if (w_xfer && (w_sel_addr != '0)) begin
            bus.rf_wr     <= 1'b1;
            bus.rf_addr   <= w_sel_addr;
            bus.rf_data   <= w_sel_data;
        end else begin
            bus.rf_wr     <= 1'b0;
        end
    end

`ifdef RR_ARB_EN
    // Round-robin pointer moves past each granted requester; soft_init leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            if (int'(w_idx) == N_REQ - 1) r_rr_ptr <= '0;
            else                          r_rr_ptr <= w_idx + PTR_W'(1);
        end
    end
`endif

endmodule
